// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode type for the arith_logic_unit block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      AND = 2'd2,
      OR  = 2'd3
   } op_code_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_datapath.sv
// ============================================================================
// Module   : alu_datapath
// Purpose  : Combinational ALU core producing the result and the four status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_datapath
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  op_code_t     op,
   output logic [N-1:0] r,
   output logic         c,
   output logic         ov,
   output logic         z,
   output logic         n
);

   logic         w_is_sub;
   logic [N-1:0] w_b_eff;
   logic [N:0]   w_sum;

   // Subtraction reuses the adder as a + ~b + 1.
   assign w_is_sub = (op == SUB);
   assign w_b_eff  = w_is_sub ? ~b : b;
   assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_is_sub};

   always_comb begin
      r  = '0;
      c  = 1'b0;
      ov = 1'b0;
      unique case (op)
         ADD: begin
            r  = w_sum[N-1:0];
            c  = w_sum[N];
            ov = (a[N-1] & b[N-1] & ~w_sum[N-1]) | (~a[N-1] & ~b[N-1] & w_sum[N-1]);
         end
         SUB: begin
            r  = w_sum[N-1:0];
            // Adder carry-out is "no borrow"; invert to report borrow.
            c  = ~w_sum[N];
            ov = (a[N-1] & ~b[N-1] & ~w_sum[N-1]) | (~a[N-1] & b[N-1] & w_sum[N-1]);
         end
         AND: r = a & b;
         OR:  r = a | b;
      endcase
   end

   assign z = ~|r;
   assign n = r[N-1];

endmodule : alu_datapath

`default_nettype wire

// File: rtl/arith_logic_unit.sv
// ============================================================================
// Module   : arith_logic_unit
// Purpose  : N-bit ADD/SUB/AND/OR unit with registered result and status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_logic_unit
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  op_code_t     op_code,
   output logic [N-1:0] rslt,
   output logic         z_f,
   output logic         n_f,
   output logic         ov_f,
   output logic         c_f
);

   logic [N-1:0] w_r;
   logic         w_c;
   logic         w_ov;
   logic         w_z;
   logic         w_n;

   logic [N-1:0] r_rslt;
   logic         r_z;
   logic         r_n;
   logic         r_ov;
   logic         r_c;

   alu_datapath #(
      .N (N)
   ) u_datapath (
      .a  (a),
      .b  (b),
      .op (op_code),
      .r  (w_r),
      .c  (w_c),
      .ov (w_ov),
      .z  (w_z),
      .n  (w_n)
   );

   // Reset state matches the flags of a zero result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rslt <= '0;
         r_z    <= 1'b1;
         r_n    <= 1'b0;
         r_ov   <= 1'b0;
         r_c    <= 1'b0;
      end else begin
         r_rslt <= w_r;
         r_z    <= w_z;
         r_n    <= w_n;
         r_ov   <= w_ov;
         r_c    <= w_c;
      end
   end

   assign rslt = r_rslt;
   assign z_f  = r_z;
   assign n_f  = r_n;
   assign ov_f = r_ov;
   assign c_f  = r_c;

endmodule : arith_logic_unit

`default_nettype wire

// File: tb/tb_arith_logic_unit.sv
// ============================================================================
// Module   : tb_arith_logic_unit
// Purpose  : Scoreboard bench for arith_logic_unit against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_logic_unit;
   import alu_pkg::*;

   localparam int N = 4;
   localparam int M = 1 << N;
   localparam int HALF = 1 << (N - 1);

   logic         clk;
   logic         rst;
   logic [N-1:0] a;
   logic [N-1:0] b;
   op_code_t     op_code;
   logic [N-1:0] rslt;
   logic         z_f;
   logic         n_f;
   logic         ov_f;
   logic         c_f;

   // Expected packing: {rslt, z, n, ov, c}
   logic [N+3:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   arith_logic_unit #(
      .N (N)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .op_code (op_code),
      .rslt    (rslt),
      .z_f     (z_f),
      .n_f     (n_f),
      .ov_f    (ov_f),
      .c_f     (c_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_signed(input int v);
      return (v >= HALF) ? v - M : v;
   endfunction

   // Reference model works on plain integers and range checks.
   function automatic logic [N+3:0] model(input int av, input int bv, input int op);
      int full, rv, s;
      logic c, ov, z, n;
      logic [31:0] rbits;
      c  = 1'b0;
      ov = 1'b0;
      rv = 0;
      case (op)
         0: begin
            full = av + bv;
            rv   = full % M;
            c    = (full >= M);
            s    = to_signed(av) + to_signed(bv);
            ov   = (s < -HALF) || (s > HALF - 1);
         end
         1: begin
            full = av - bv;
            rv   = (full + M) % M;
            c    = (av < bv);
            s    = to_signed(av) - to_signed(bv);
            ov   = (s < -HALF) || (s > HALF - 1);
         end
         2: rv = av & bv;
         default: rv = av | bv;
      endcase
      z = (rv == 0);
      n = (rv >= HALF);
      rbits = rv;
      return {rbits[N-1:0], z, n, ov, c};
   endfunction

   task automatic check(input string name, input logic [N+3:0] act, input logic [N+3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got rslt=%h z=%b n=%b ov=%b c=%b, expected rslt=%h z=%b n=%b ov=%b c=%b",
                  name, act[N+3:4], act[3], act[2], act[1], act[0],
                  exp[N+3:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Apply inputs now and queue the expected registered response.
   task automatic drive(input int av, input int bv, input int op);
      logic [31:0] a32, b32;
      a32 = av;
      b32 = bv;
      a       = a32[N-1:0];
      b       = b32[N-1:0];
      op_code = op_code_t'(op[1:0]);
      exp_q.push_back(model(av, bv, op));
   endtask

   task automatic apply(input int av, input int bv, input int op);
      @(negedge clk);
      drive(av, bv, op);
   endtask

   // Monitor: output is present one edge after each queued stimulus.
   initial begin
      logic [N+3:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("scoreboard", {rslt, z_f, n_f, ov_f, c_f}, exp);
         end
      end
   end

   localparam logic [N+3:0] RESET_VAL = {{N{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst     = 1'b1;
      a       = '0;
      b       = '0;
      op_code = ADD;
      #12;
      check("reset_state", {rslt, z_f, n_f, ov_f, c_f}, RESET_VAL);
      @(negedge clk);
      rst = 1'b0;

      apply(7, 1, 0);
      apply(15, 1, 0);
      apply(3, 5, 1);
      apply(8, 1, 1);
      apply(12, 10, 2);
      apply(0, 0, 3);
      apply(0, 0, 1);
      apply(15, 15, 0);
      apply(7, 1, 0);

      // Asynchronous reset between edges while the output is nonzero.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", {rslt, z_f, n_f, ov_f, c_f}, RESET_VAL);
      a       = 4'h9;
      b       = 4'h9;
      op_code = ADD;
      @(posedge clk);
      #1;
      check("reset_hold", {rslt, z_f, n_f, ov_f, c_f}, RESET_VAL);
      @(negedge clk);
      rst = 1'b0;
      drive(6, 5, 0);

      for (int i = 0; i < 300; i++) begin
         apply(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)), int'($urandom_range(3)));
      end

      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_arith_logic_unit

`default_nettype wire
